// File: rtl/lif_decoder_pkg.sv
// Shared types and default widths for the LIF spike-rate decoder.
// Also holds the saturation limits that match the neuron top's defaults.
package lif_decoder_pkg;

    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_WIN_W = 16;

    // All-ones value for a field of width w (w <= 32)
    function automatic int unsigned all_ones(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    localparam int unsigned CNT_MAX = all_ones(DEF_CNT_W);
    localparam int unsigned ISI_MAX = all_ones(DEF_WIN_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for the neuron spike line.
// The edge output is combinational, so it is valid in the same cycle the line rises.
module spike_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic spike_i,
    output logic spike_edge_o
);

    logic spike_q;
    logic spike_d;

    // Next-state: spike line delayed by one cycle
    always_comb begin
        spike_d = spike_i;
    end

    // Delay register, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike_d;
        end
    end

    assign spike_edge_o = spike_i & ~spike_q;

endmodule

// File: rtl/lif_spike_rate_decoder.sv
// Spike-rate decoder: counts rising edges of the spike line over back-to-back
// windows of win_len cycles and hands each count out over valid/ready.
// Optional feature macro: ISI_MEASURE_EN adds minimum inter-spike-interval tracking;
// without it isi_min is tied to zero.
module lif_spike_rate_decoder
    import lif_decoder_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIN_W-1:0] win_len,
    input  logic             spike_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             overrun,
    output logic             busy,
    output logic [WIN_W-1:0] isi_min
);

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             cnt_valid_q, cnt_valid_d;
    logic             overrun_q, overrun_d;

    logic             spike_edge;
    logic             start_ok;
    logic             win_last;
    logic             load;
    logic             res_load;
    logic [CNT_W-1:0] acc_sum;

    spike_edge_detect u_edge (
        .clk          (clk),
        .rst          (rst),
        .spike_i      (spike_in),
        .spike_edge_o (spike_edge)
    );

    assign start_ok = en & (win_len != '0);
    assign win_last = (state_q == RUN) && (win_cnt_q == '0);
    // A new window starts from IDLE or reloads on the last cycle of the current one
    assign load     = start_ok & ((state_q == IDLE) | win_last);
    // Result is dropped only when an older one is still pending and not being taken
    assign res_load = win_last & ~(cnt_valid_q & ~cnt_ready);
    // Saturating count including the edge of the current cycle
    assign acc_sum  = (spike_edge && (acc_q != '1)) ? acc_q + CNT_W'(1) : acc_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (win_last && !start_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == RUN);
    end

    // Window counter and spike accumulator next-state
    always_comb begin
        win_cnt_d = win_cnt_q;
        acc_d     = acc_q;
        if (load) begin
            win_cnt_d = win_len - WIN_W'(1);
            acc_d     = '0;
        end else if ((state_q == RUN) && !win_last) begin
            win_cnt_d = win_cnt_q - WIN_W'(1);
            acc_d     = acc_sum;
        end
    end

    // Result register and handshake next-state
    always_comb begin
        cnt_out_d   = cnt_out_q;
        cnt_valid_d = cnt_valid_q;
        overrun_d   = overrun_q;
        if (win_last) begin
            if (res_load) begin
                cnt_out_d   = acc_sum;
                cnt_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (cnt_valid_q && cnt_ready) begin
            cnt_valid_d = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q   <= '0;
            acc_q       <= '0;
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            acc_q       <= acc_d;
            cnt_out_q   <= cnt_out_d;
            cnt_valid_q <= cnt_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cnt_out   = cnt_out_q;
    assign cnt_valid = cnt_valid_q;
    assign overrun   = overrun_q;

`ifdef ISI_MEASURE_EN
    logic [WIN_W-1:0] isi_cnt_q, isi_cnt_d;
    logic [WIN_W-1:0] isi_acc_q, isi_acc_d;
    logic [WIN_W-1:0] isi_min_q, isi_min_d;
    logic             isi_seen_q, isi_seen_d;
    logic [WIN_W-1:0] isi_res;

    // Running minimum including an interval that closes in this cycle
    always_comb begin
        isi_res = isi_acc_q;
        if (spike_edge && isi_seen_q && (isi_cnt_q < isi_acc_q)) begin
            isi_res = isi_cnt_q;
        end
    end

    // ISI counter, first-edge flag, minimum and result next-state
    always_comb begin
        isi_cnt_d  = isi_cnt_q;
        isi_acc_d  = isi_acc_q;
        isi_seen_d = isi_seen_q;
        isi_min_d  = isi_min_q;
        if (load) begin
            isi_cnt_d  = '0;
            isi_acc_d  = '1;
            isi_seen_d = 1'b0;
        end else if (state_q == RUN) begin
            isi_acc_d = isi_res;
            if (spike_edge) begin
                // Cycle after an edge is one cycle since that edge
                isi_cnt_d  = WIN_W'(1);
                isi_seen_d = 1'b1;
            end else if (isi_cnt_q != '1) begin
                isi_cnt_d = isi_cnt_q + WIN_W'(1);
            end
        end
        if (res_load) begin
            isi_min_d = isi_res;
        end
    end

    // ISI registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isi_cnt_q  <= '0;
            isi_acc_q  <= '1;
            isi_seen_q <= 1'b0;
            isi_min_q  <= '0;
        end else begin
            isi_cnt_q  <= isi_cnt_d;
            isi_acc_q  <= isi_acc_d;
            isi_seen_q <= isi_seen_d;
            isi_min_q  <= isi_min_d;
        end
    end

    assign isi_min = isi_min_q;
`else
    assign isi_min = '0;
`endif

endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
// Directed self-checking bench for lif_spike_rate_decoder (default widths).
// Build with ISI_MEASURE_EN defined to check the interval measurement values.
module tb_lif_spike_rate_decoder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] win_len;
    logic        spike_in;
    logic [7:0]  cnt_out;
    logic        cnt_valid;
    logic        cnt_ready;
    logic        overrun;
    logic        busy;
    logic [15:0] isi_min;

    int checks   = 0;
    int failures = 0;
    int n;

`ifdef ISI_MEASURE_EN
    localparam logic [15:0] IsiThree  = 16'd2;
    localparam logic [15:0] IsiSingle = 16'hFFFF;
`else
    localparam logic [15:0] IsiThree  = 16'd0;
    localparam logic [15:0] IsiSingle = 16'd0;
`endif

    lif_spike_rate_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .win_len   (win_len),
        .spike_in  (spike_in),
        .cnt_out   (cnt_out),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .overrun   (overrun),
        .busy      (busy),
        .isi_min   (isi_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic tick(input int cnt);
        repeat (cnt) @(posedge clk);
        #1;
    endtask

    // One-cycle spike followed by one low cycle
    task automatic pulse();
        spike_in = 1'b1;
        tick(1);
        spike_in = 1'b0;
        tick(1);
    endtask

    task automatic wait_valid(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!cnt_valid && cyc < budget) begin
            tick(1);
            cyc++;
        end
        chk(tag, {31'b0, cnt_valid}, 32'd1);
    endtask

    task automatic consume();
        cnt_ready = 1'b1;
        tick(1);
        cnt_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        win_len   = '0;
        spike_in  = 1'b0;
        cnt_ready = 1'b0;
        tick(2);
        chk("rst_cnt_out", cnt_out, 0);
        chk("rst_valid", cnt_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_isi", isi_min, 0);
        rst = 1'b0;
        tick(1);

        // Test 1: window of 10, three single-cycle spikes
        win_len = 16'd10;
        en      = 1'b1;
        tick(1);
        chk("t1_busy", busy, 1);
        en = 1'b0;
        tick(1);
        pulse();
        pulse();
        pulse();
        tick(2);
        chk("t1_not_early", cnt_valid, 0);
        wait_valid("t1_valid", 20, n);
        chk("t1_latency", n, 1);
        chk("t1_cnt", cnt_out, 3);
        chk("t1_idle", busy, 0);
        cnt_ready = 1'b1;
        tick(1);
        cnt_ready = 1'b0;
        chk("t1_valid_drop", cnt_valid, 0);

        // Test 2: level held 20 cycles counts once
        win_len = 16'd32;
        en      = 1'b1;
        tick(1);
        en       = 1'b0;
        spike_in = 1'b1;
        tick(20);
        spike_in = 1'b0;
        wait_valid("t2_valid", 50, n);
        chk("t2_latency", n, 12);
        chk("t2_cnt", cnt_out, 1);
        consume();

        // Test 3: 300 spikes saturate an 8-bit count
        win_len = 16'd1000;
        en      = 1'b1;
        tick(1);
        en = 1'b0;
        for (int i = 0; i < 300; i++) pulse();
        wait_valid("t3_valid", 1000, n);
        chk("t3_latency", n, 400);
        chk("t3_cnt", cnt_out, 255);
        consume();

        // Test 4b: ready on the exact window-end cycle accepts and reloads
        win_len = 16'd5;
        en      = 1'b1;
        tick(1);
        pulse();
        tick(3);
        chk("t4b_w1_valid", cnt_valid, 1);
        chk("t4b_w1_cnt", cnt_out, 1);
        pulse();
        pulse();
        cnt_ready = 1'b1;
        en        = 1'b0;
        tick(1);
        cnt_ready = 1'b0;
        chk("t4b_valid", cnt_valid, 1);
        chk("t4b_cnt", cnt_out, 2);
        chk("t4b_overrun", overrun, 0);
        chk("t4b_idle", busy, 0);
        consume();
        chk("t4b_consumed", cnt_valid, 0);

        // Test 4a: ready held low across two back-to-back windows
        en = 1'b1;
        tick(1);
        pulse();
        tick(3);
        chk("t4a_w1_cnt", cnt_out, 1);
        chk("t4a_reload_busy", busy, 1);
        pulse();
        pulse();
        tick(1);
        chk("t4a_overrun", overrun, 1);
        chk("t4a_held_cnt", cnt_out, 1);
        chk("t4a_held_valid", cnt_valid, 1);
        en = 1'b0;
        tick(1);

        // Test 5: asynchronous reset mid-window
        rst = 1'b1;
        #1;
        chk("t5_async_cnt", cnt_out, 0);
        chk("t5_async_valid", cnt_valid, 0);
        chk("t5_async_overrun", overrun, 0);
        chk("t5_async_busy", busy, 0);
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("t5_no_result", cnt_valid, 0);
        chk("t5_idle", busy, 0);
        win_len = 16'd0;
        en      = 1'b1;
        tick(3);
        chk("t5_zero_len_busy", busy, 0);
        en = 1'b0;

        // Test 6: minimum inter-spike interval, edges at window cycles 2,7,9
        win_len = 16'd16;
        en      = 1'b1;
        tick(1);
        en = 1'b0;
        tick(2);
        spike_in = 1'b1;
        tick(1);
        spike_in = 1'b0;
        tick(4);
        spike_in = 1'b1;
        tick(1);
        spike_in = 1'b0;
        tick(1);
        spike_in = 1'b1;
        tick(1);
        spike_in = 1'b0;
        wait_valid("t6_valid", 30, n);
        chk("t6_cnt", cnt_out, 3);
        chk("t6_isi", isi_min, IsiThree);
        consume();

        // Single edge in a window
        en = 1'b1;
        tick(1);
        en = 1'b0;
        pulse();
        wait_valid("t6s_valid", 30, n);
        chk("t6s_cnt", cnt_out, 1);
        chk("t6s_isi", isi_min, IsiSingle);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
